aes_uart_frame_ctrl: RTL

Command/frame sequencer between the UART byte link and the AES-128 datapath. It parses framed byte commands from the UART receiver and assembles a 128-bit key and 128-bit plaintext block. It launches the AES core, captures the ciphertext and streams it back byte-by-byte to the UART transmitter. It owns all sequencing, error recovery and bypass handling, so the AES core and UART blocks stay free of control logic.

---
 rtl/aes_uart_frame_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_uart_frame_ctrl.sv
// AES/UART frame controller: parses key/data frames from the UART,
// launches the AES core (or bypasses it) and streams the result back.
// Ports: clk, rst_n; rx_valid/rx_data from the UART receiver;
// aes_enable selects encrypt or bypass; aes_key/aes_block/aes_start and
// aes_done/aes_result talk to the AES core; tx_data/tx_valid/tx_ready
// feed the UART transmitter; frames_received, key_loaded, busy and err
// report status.
module aes_uart_frame_ctrl #(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter int          TO_W           = 20,
    parameter logic [7:0]  CMD_KEY        = 8'h4B,
    parameter logic [7:0]  CMD_DATA       = 8'h44
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         aes_enable,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         frames_received,
    output logic         key_loaded,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        RUN,
        WAIT,
        SEND
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_d;
    logic [127:0]    result;
    logic [3:0]      cnt;
    logic [TO_W-1:0] to_cnt;

    logic err_d;
    logic fin_d;
    logic ld_key;
    logic ld_data;
    logic key_clr;
    logic key_set;
    logic cnt_clr;
    logic bypass;
    logic capture;
    logic xfer;
    logic in_load;

    assign tx_valid = (state == SEND);
    assign tx_data  = result[127:120];
    assign busy     = (state != IDLE);
    assign in_load  = (state == LOAD_KEY) || (state == LOAD_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        err_d     = 1'b0;
        fin_d     = 1'b0;
        ld_key    = 1'b0;
        ld_data   = 1'b0;
        key_clr   = 1'b0;
        key_set   = 1'b0;
        cnt_clr   = 1'b0;
        bypass    = 1'b0;
        capture   = 1'b0;
        xfer      = 1'b0;
        aes_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_KEY) begin
                        state_d = LOAD_KEY;
                        key_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (rx_data == CMD_DATA && key_loaded) begin
                        state_d = LOAD_DATA;
                        cnt_clr = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_KEY: begin
                if (rx_valid) begin
                    ld_key = 1'b1;
                    if (cnt == 4'd15) begin
                        key_set = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD_DATA: begin
                if (rx_valid) begin
                    ld_data = 1'b1;
                    if (cnt == 4'd15) begin
                        state_d = RUN;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN: begin
                err_d = rx_valid;
                if (aes_enable) begin
                    aes_start = 1'b1;
                    state_d   = WAIT;
                end else begin
                    bypass  = 1'b1;
                    state_d = SEND;
                end
            end
            WAIT: begin
                err_d = rx_valid;
                if (aes_done) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    xfer = 1'b1;
                    if (cnt == 4'd15) begin
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                // The completion pulse wins over a stray byte error
                // so the two status pulses never coincide.
                err_d = rx_valid && !fin_d;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aes_key         <= '0;
            aes_block       <= '0;
            result          <= '0;
            cnt             <= '0;
            to_cnt          <= '0;
            key_loaded      <= 1'b0;
            err             <= 1'b0;
            frames_received <= 1'b0;
        end else begin
            err             <= err_d;
            frames_received <= fin_d;
            if (ld_key) begin
                aes_key <= {aes_key[119:0], rx_data};
            end
            if (ld_data) begin
                aes_block <= {aes_block[119:0], rx_data};
            end
            if (key_clr) begin
                key_loaded <= 1'b0;
            end else if (key_set) begin
                key_loaded <= 1'b1;
            end
            // 4-bit count wraps to 0 after the 16th byte of a frame.
            if (cnt_clr) begin
                cnt <= '0;
            end else if (ld_key || ld_data || xfer) begin
                cnt <= cnt + 4'd1;
            end
            if (in_load && !rx_valid && state_d == state) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (bypass) begin
                result <= aes_block;
            end else if (capture) begin
                result <= aes_result;
            end else if (xfer) begin
                result <= {result[119:0], 8'h00};
            end
        end
    end

endmodule
